// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the handshake controller.
//   HS_RB / HS_FH     : handshake byte codes pre-decoded by the receiver
//   uart_rx_state_t   : receiver FSM state encoding
//   SYNC_DEPTH        : flop count of the rxd synchroniser
//   clks_per_bit()    : system clocks per serial bit, truncated
package uart_pkg;

  localparam logic [7:0] HS_RB = 8'hAA;
  localparam logic [7:0] HS_FH = 8'hDD;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for a single asynchronous input.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset, loads RESET_VAL into every stage
//   d        : asynchronous input
//   q        : synchronised output, DEPTH cycles behind d
module uart_sync #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {DEPTH{RESET_VAL}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and handshake byte pre-decode.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   rxd          : raw serial line, idle high, asynchronous to clk
//   rx_data      : last good byte, held until the next one
//   rx_valid     : one-cycle strobe, rx_data valid this cycle
//   rx_frame_err : one-cycle strobe, stop bit sampled low
//   hs_rb        : with rx_valid when the byte is HS_RB
//   hs_fh        : with rx_valid when the byte is HS_FH
//   rx_busy      : high while a frame is being received (START/DATA/STOP)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_IDLE | line not yet seen idle (after reset or framing error)
// IDLE      | line idle, waiting for a falling edge
// START     | counting to the middle of the start bit to confirm it
// DATA      | sampling the eight data bits one bit period apart
// STOP      | sampling the stop bit, emitting the byte or an error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 7_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       hs_rb,
  output logic       hs_fh,
  output logic       rx_busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_BIT    = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_DEPTH);

  logic           rxd_s;
  uart_rx_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  uart_sync #(
    .DEPTH     (SYNC_DEPTH),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      hs_rb        <= 1'b0;
      hs_fh        <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      hs_rb        <= 1'b0;
      hs_fh        <= 1'b0;

      case (state)
        // The synchroniser resets high, so its first SYNC_DEPTH outputs after
        // reset are not real line samples. Requiring SYNC_DEPTH+1 consecutive
        // highs keeps a line held low through reset from looking idle.
        WAIT_IDLE: begin
          rx_busy <= 1'b0;
          if (!rxd_s) begin
            cnt <= '0;
          end else if (cnt == CNT_SETTLE) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE: begin
          if (!rxd_s) begin
            cnt     <= '0;
            rx_busy <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxd_s) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              rx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Leaving at mid-stop-bit gives half a bit of slack before the next
        // start edge of a back-to-back frame.
        STOP: begin
          if (cnt == CNT_BIT) begin
            cnt     <= '0;
            rx_busy <= 1'b0;
            if (rxd_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              hs_rb    <= (shreg == HS_RB);
              hs_fh    <= (shreg == HS_FH);
              state    <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt     <= '0;
          rx_busy <= 1'b0;
          state   <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB     = 60;
  localparam int LATENCY = 572;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       hs_rb;
  logic       hs_fh;
  logic       rx_busy;

  typedef struct {
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   valid_times[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int rb_cnt = 0;
  int fh_cnt = 0;

  uart_rx #(
    .CLK_FREQ_HZ (7_000_000),
    .BAUD_RATE   (115200)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .hs_rb        (hs_rb),
    .hs_fh        (hs_fh),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every rx_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_frame_err) begin
        err_cnt++;
        check("err_with_valid", int'(rx_valid), 0);
      end
      if (hs_rb) rb_cnt++;
      if (hs_fh) fh_cnt++;
      if ((hs_rb || hs_fh) && !rx_valid) check("hs_without_valid", 0, 1);
      if (rx_valid) begin
        valid_cnt++;
        valid_times.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rx_data", int'(rx_data), int'(e.data));
          check("hs_rb", int'(hs_rb), int'(e.data == 8'hAA));
          check("hs_fh", int'(hs_fh), int'(e.data == 8'hDD));
          check("latency", cyc - e.t0, LATENCY);
        end
      end
    end
  end

  // Called on a falling edge; the first rising edge after it is N0.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit expect_ok);
    if (expect_ok) sb.push_back('{data: b, t0: cyc + 1});
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(rx_frame_err), 0);
    check("rst_hs_rb", int'(hs_rb), 0);
    check("rst_hs_fh", int'(hs_fh), 0);
    check("rst_busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Default frame
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check("f55_valid_cnt", valid_cnt, 1);
    check("f55_err_cnt", err_cnt, 0);
    check("f55_rb_cnt", rb_cnt, 0);
    check("f55_fh_cnt", fh_cnt, 0);
    check("f55_data", int'(rx_data), 8'h55);

    // Handshake bytes
    send_byte(8'hAA, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    send_byte(8'hDD, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check("hs_valid_cnt", valid_cnt, 3);
    check("hs_rb_cnt", rb_cnt, 1);
    check("hs_fh_cnt", fh_cnt, 1);

    // Glitch: 20 low cycles, START rejects it at its half-bit sample
    busy_cycles = 0;
    for (int i = 0; i < 120; i++) begin
      rxd = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rx_busy) busy_cycles++;
    end
    check("glitch_busy_cycles", busy_cycles, 30);
    check("glitch_valid_cnt", valid_cnt, 3);
    check("glitch_err_cnt", err_cnt, 0);

    // Framing error, then a long break, then a good byte
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("ferr_err_cnt", err_cnt, 1);
    check("ferr_valid_cnt", valid_cnt, 3);
    check("ferr_data_held", int'(rx_data), 8'hDD);
    send_byte(8'h81, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check("f81_valid_cnt", valid_cnt, 4);
    check("f81_data", int'(rx_data), 8'h81);
    check("f81_err_cnt", err_cnt, 1);

    // Back-to-back frames
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check("b2b_valid_cnt", valid_cnt, 6);
    if (valid_times.size() >= 6) begin
      int gap;
      gap = valid_times[5] - valid_times[4];
      check("b2b_gap_in_range", int'(gap >= 599 && gap <= 601), 1);
    end else begin
      check("b2b_valid_times", valid_times.size(), 6);
    end

    // Reset mid-DATA, released with the line still low
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("pre_rst_busy", int'(rx_busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(rx_busy), 0);
    check("mid_rst_data", int'(rx_data), 0);
    check("mid_rst_valid", int'(rx_valid), 0);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("low_after_rst_valid_cnt", valid_cnt, 6);
    check("low_after_rst_err_cnt", err_cnt, 1);
    check("low_after_rst_busy", int'(rx_busy), 0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h5A, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check("f5a_valid_cnt", valid_cnt, 7);
    check("f5a_data", int'(rx_data), 8'h5A);
    check("final_err_cnt", err_cnt, 1);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that feeds the UART handshake/fetch controller. Synchronises the raw `rxd` line, recovers 8N1 frames with a mid-bit sampling counter, and presents each byte with a one-cycle valid strobe. Flags framing errors and pre-decodes the two handshake bytes, so the controller's IDLE state can act on them directly.

## Interface
- `CLK_FREQ_HZ`, 7_000_000: system clock frequency.
- `BAUD_RATE`, 115200: line rate.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rxd`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last received byte; held until the next valid byte.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid in this cycle.
- `rx_frame_err`  out  1  one-cycle pulse; the stop bit was sampled low.
- `hs_rb`  out  1  pulse with `rx_valid` when the byte is 0xAA.
- `hs_fh`  out  1  pulse with `rx_valid` when the byte is 0xDD.
- `rx_busy`  out  1  high in START, DATA and STOP.

## Operation
- Derived constants:
  - `CPB = CLK_FREQ_HZ / BAUD_RATE`, integer truncation; 60 at defaults.
  - `HALF = CPB / 2`, i.e. 30.
  - Bit counter width is `$clog2(CPB)`.
- Two-flop synchroniser on `rxd` produces `rxd_s`. Both flops reset to 1.
- States:
  - WAIT_IDLE: go to IDLE on `rxd_s == 1`.
  - IDLE: on `rxd_s == 0`, clear the counter and go to START.
  - START: at `cnt == HALF-1`, sample `rxd_s`.
    - 0: clear `cnt` and `bit_idx`, go to DATA.
    - 1: glitch; go to IDLE with no output.
  - DATA: at `cnt == CPB-1`, sample and shift right, inserting the sample at bit 7, so the byte is received LSB first. Clear `cnt` and increment `bit_idx`. After the 8th bit, go to STOP.
  - STOP: at `cnt == CPB-1`, sample.
    - 1: load `rx_data`, pulse `rx_valid` and the matching `hs_*`, go to IDLE.
    - 0: pulse `rx_frame_err` only, leave `rx_data` unchanged, go to WAIT_IDLE.
- Reset state is WAIT_IDLE. A line held low through reset release is not treated as a start bit.
- The return to IDLE happens mid-stop-bit, which leaves half a bit of margin for back-to-back frames.
- Reset values: `rx_data` = 0x00; `rx_valid`, `rx_frame_err`, `hs_rb`, `hs_fh`, `rx_busy` = 0.
- Reset asserted mid-frame aborts the frame immediately. No strobes are emitted.
- `hs_rb` and `hs_fh` are never asserted without `rx_valid`, and never on a framing error.
- There is no flow control. The consumer must accept `rx_valid` in the cycle it is high.

## Timing
- Let N0 be the first clock edge at which `rxd` is low.
  - N0+1: `rxd_s` goes low.
  - N0+2: START is entered.
- Sample points after N0:
  - Start bit: N0+2+HALF.
  - Data bit k (k = 0..7): N0+2+HALF+(k+1)·CPB.
  - Stop bit: N0+2+HALF+9·CPB.
- Strobes are registered. They are high for exactly the cycle following the stop-sample edge, i.e. N0+572 at default parameters.
- Back-to-back frames: consecutive `rx_valid` pulses are 10·CPB = 600 cycles apart, with ±1 cycle for synchroniser phase.
- Glitch rejection: a low pulse shorter than about HALF cycles is discarded.

## Structure
- `uart_pkg`, shared with the handshake controller:
  - `HS_RB = 8'hAA` and `HS_FH = 8'hDD`.
  - `uart_rx_state_t`, a 3-bit enum: WAIT_IDLE, IDLE, START, DATA, STOP.
  - function `clks_per_bit(clk_hz, baud)`.
- Sub-module `uart_sync`: parameterised-depth synchroniser (depth 2 here), with its reset value as a parameter. The controller reuses it for other asynchronous inputs.

## Test plan
- Default frame: send 0x55 at CPB=60 → one `rx_valid` at N0+572 with `rx_data` = 0x55; `rx_frame_err`, `hs_rb`, `hs_fh` all stay 0.
- Handshake bytes: send 0xAA then 0xDD → `hs_rb` coincides with the first `rx_valid`, `hs_fh` with the second; each asserts exactly once.
- Glitch: `rxd` low for 20 cycles, then high → returns to IDLE; no strobes; `rx_busy` high for about 30 cycles only.
- Framing error: send 0x3C with the stop bit low, hold the line low for 2000 cycles, release, then send 0x81 →
  - one `rx_frame_err` and no `rx_valid` for the first frame;
  - `rx_data` stays at its prior value;
  - 0x81 is then received correctly.
- Back-to-back: send 0x00 then 0xFF with no idle gap → two `rx_valid` pulses 600±1 cycles apart, carrying 0x00 and 0xFF.
- Reset: assert `rst_n` mid-DATA, release while `rxd` is still low → outputs reset to 0 immediately; no strobe until the line returns high; a following 0x5A is received correctly.
